multi_cycle_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-opcode core. It steps each instruction through fetch, decode, execute, memory and writeback states, and owns the program counter. It drives the per-cycle enables that gate the combinational control decoder's outputs onto the register file, data memory and instruction register. It also implements the start/done program handshake and keeps cycle and retired-instruction counters for performance reporting.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/latency_timer.sv | 28 ++
 rtl/multi_cycle_sequencer.sv | 144 ++++++++++++++
 tb/tb_multi_cycle_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-opcode core: sequencer states and opcode encodings.
package cpu_pkg;

  localparam int unsigned OPW     = 3;
  localparam int unsigned TIMER_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } seq_state_t;

  localparam logic [OPW-1:0] OP_ADD   = 3'b000;
  localparam logic [OPW-1:0] OP_ROR   = 3'b001;
  localparam logic [OPW-1:0] OP_NAND  = 3'b010;
  localparam logic [OPW-1:0] OP_LOAD  = 3'b011;
  localparam logic [OPW-1:0] OP_STORE = 3'b100;
  localparam logic [OPW-1:0] OP_MOVE  = 3'b101;
  localparam logic [OPW-1:0] OP_BNE   = 3'b110;
  localparam logic [OPW-1:0] OP_SET   = 3'b111;

endpackage

// File: rtl/latency_timer.sv
// Down-counter that times the data-memory access window.
module latency_timer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               expired_c
);

  logic [TIMER_W-1:0] count;

  // Load on entry to the window, then count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle instruction sequencer: owns pc, per-cycle enables, start/done handshake
// and the performance counters.
module multi_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PCW     = 10,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      opcode,
  input  logic            halt_req,
  input  logic            ne_flag,
  input  logic [PCW-1:0]  branch_target,
  output logic [PCW-1:0]  pc,
  output logic            ir_load,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            done,
  output logic [CNTW-1:0] cycle_count,
  output logic [CNTW-1:0] instr_count
);

  seq_state_t     state;
  seq_state_t     state_n;
  logic           start_q;
  logic           start_rise_c;
  logic [PCW-1:0] pc_n;
  logic           retire_c;
  logic           clear_c;
  logic           active_c;
  logic           timer_load_c;
  logic           timer_exp_c;
  logic           mem_store_q;
  logic           mem_store_n;

  assign start_rise_c = start & ~start_q;
  assign active_c     = (state != IDLE) && (state != HALT);

  // Memory wait window, armed on the EXEC to MEM transition.
  latency_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load_c),
    .load_val  (TIMER_W'(MEM_LAT - 1)),
    .dec       (state == MEM),
    .expired_c (timer_exp_c)
  );

  // Next state, next pc and retire/clear strobes.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    retire_c     = 1'b0;
    clear_c      = 1'b0;
    timer_load_c = 1'b0;
    mem_store_n  = mem_store_q;
    case (state)
      IDLE, HALT: begin
        if (start_rise_c) begin
          state_n = FETCH;
          clear_c = 1'b1;
        end
      end
      FETCH:  state_n = DECODE;
      DECODE: state_n = halt_req ? HALT : EXEC;
      EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: begin
            state_n      = MEM;
            timer_load_c = 1'b1;
            mem_store_n  = (opcode == OP_STORE);
          end
          OP_BNE: begin
            state_n  = FETCH;
            retire_c = 1'b1;
            pc_n     = ne_flag ? branch_target : pc + PCW'(1);
          end
          default: state_n = WB;
        endcase
      end
      MEM: begin
        if (timer_exp_c) begin
          if (mem_store_q) begin
            state_n  = FETCH;
            retire_c = 1'b1;
            pc_n     = pc + PCW'(1);
          end else begin
            state_n = WB;
          end
        end
      end
      WB: begin
        state_n  = FETCH;
        retire_c = 1'b1;
        pc_n     = pc + PCW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pc, saturating counters and enables registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      mem_store_q <= 1'b0;
      pc          <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      ir_load     <= 1'b0;
      reg_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      start_q     <= start;
      mem_store_q <= mem_store_n;
      if (clear_c) begin
        pc          <= '0;
        cycle_count <= '0;
        instr_count <= '0;
      end else begin
        pc <= pc_n;
        if (active_c && (cycle_count != '1)) begin
          cycle_count <= cycle_count + CNTW'(1);
        end
        if (retire_c && (instr_count != '1)) begin
          instr_count <= instr_count + CNTW'(1);
        end
      end
      ir_load <= (state_n == FETCH);
      reg_we  <= (state_n == WB);
      mem_re  <= (state_n == MEM) && !mem_store_n;
      mem_we  <= timer_load_c && mem_store_n;
      done    <= (state_n == HALT);
    end
  end

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Self-checking bench for multi_cycle_sequencer: two instances with different
// parameters, program tables driving the decoder inputs, and a per-instruction model.
`timescale 1ns/1ps
module tb_multi_cycle_sequencer;
  import cpu_pkg::*;

  localparam int unsigned A_PCW   = 4;
  localparam int unsigned A_LAT   = 2;
  localparam int unsigned A_CNTW  = 16;
  localparam int unsigned A_DEPTH = 1 << A_PCW;
  localparam int unsigned B_PCW   = 10;
  localparam int unsigned B_LAT   = 3;
  localparam int unsigned B_CNTW  = 4;
  localparam int          B_SAT   = (1 << B_CNTW) - 1;
  localparam int          BUDGET  = 3000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals and program
  logic              a_start = 1'b0;
  logic [2:0]        a_opcode;
  logic              a_halt, a_ne;
  logic [A_PCW-1:0]  a_tgt, a_pc;
  logic              a_ir_load, a_reg_we, a_mem_re, a_mem_we, a_done;
  logic [A_CNTW-1:0] a_cyc, a_ins;
  logic [2:0]        pa_op   [A_DEPTH];
  logic              pa_halt [A_DEPTH];
  logic              pa_ne   [A_DEPTH];
  logic [A_PCW-1:0]  pa_tgt  [A_DEPTH];

  assign a_opcode = pa_op[a_pc];
  assign a_halt   = pa_halt[a_pc];
  assign a_ne     = pa_ne[a_pc];
  assign a_tgt    = pa_tgt[a_pc];

  // Instance B signals and program
  logic              b_start = 1'b0;
  logic [2:0]        b_opcode;
  logic              b_halt;
  logic [B_PCW-1:0]  b_pc;
  logic              b_ir_load, b_reg_we, b_mem_re, b_mem_we, b_done;
  logic [B_CNTW-1:0] b_cyc, b_ins;
  logic [2:0]        pb_op   [32];
  logic              pb_halt [32];

  assign b_opcode = pb_op[b_pc[4:0]];
  assign b_halt   = pb_halt[b_pc[4:0]];

  multi_cycle_sequencer #(.PCW(A_PCW), .MEM_LAT(A_LAT), .CNTW(A_CNTW)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .opcode(a_opcode), .halt_req(a_halt),
    .ne_flag(a_ne), .branch_target(a_tgt), .pc(a_pc), .ir_load(a_ir_load),
    .reg_we(a_reg_we), .mem_re(a_mem_re), .mem_we(a_mem_we), .done(a_done),
    .cycle_count(a_cyc), .instr_count(a_ins)
  );

  multi_cycle_sequencer #(.PCW(B_PCW), .MEM_LAT(B_LAT), .CNTW(B_CNTW)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .opcode(b_opcode), .halt_req(b_halt),
    .ne_flag(1'b0), .branch_target('0), .pc(b_pc), .ir_load(b_ir_load),
    .reg_we(b_reg_we), .mem_re(b_mem_re), .mem_we(b_mem_we), .done(b_done),
    .cycle_count(b_cyc), .instr_count(b_ins)
  );

  // Cumulative enable monitor, sampled mid-cycle.
  int   a_irl_q[$];
  int   a_nreg = 0, a_nre = 0, a_nwe = 0, a_dbl = 0;
  int   b_nre = 0, b_nwe = 0;
  logic a_we_prev = 1'b0;
  always @(negedge clk) begin
    if (a_ir_load) a_irl_q.push_back(int'(a_pc));
    if (a_reg_we) a_nreg++;
    if (a_mem_re) a_nre++;
    if (a_mem_we) a_nwe++;
    if (a_mem_we && a_we_prev) a_dbl++;
    a_we_prev = a_mem_we;
    if (b_mem_re) b_nre++;
    if (b_mem_we) b_nwe++;
  end

  int tests = 0;
  int fails = 0;

  // Reference model results for instance A
  int m_cyc, m_ins, m_pc, m_reg, m_re, m_we;
  int m_pcs[$];

  // Walk the program one instruction at a time using the per-class cycle costs.
  task automatic model_a();
    int p;
    p = 0;
    m_cyc = 0; m_ins = 0; m_reg = 0; m_re = 0; m_we = 0;
    m_pcs.delete();
    for (int guard = 0; guard < 200; guard++) begin
      m_pcs.push_back(p);
      if (pa_halt[p]) begin
        m_cyc += 2;
        break;
      end
      m_ins++;
      case (pa_op[p])
        OP_LOAD:  begin m_cyc += 4 + A_LAT; m_re += A_LAT; m_reg++; p = (p + 1) % int'(A_DEPTH); end
        OP_STORE: begin m_cyc += 3 + A_LAT; m_we++; p = (p + 1) % int'(A_DEPTH); end
        OP_BNE:   begin m_cyc += 3; p = pa_ne[p] ? int'(pa_tgt[p]) : (p + 1) % int'(A_DEPTH); end
        default:  begin m_cyc += 4; m_reg++; p = (p + 1) % int'(A_DEPTH); end
      endcase
    end
    m_pc = p;
  endtask

  task automatic clear_prog_a();
    for (int i = 0; i < int'(A_DEPTH); i++) begin
      pa_op[i] = OP_ADD; pa_halt[i] = 1'b1; pa_ne[i] = 1'b0; pa_tgt[i] = '0;
    end
  endtask

  task automatic clear_prog_b();
    for (int i = 0; i < 32; i++) begin
      pb_op[i] = OP_ADD; pb_halt[i] = 1'b1;
    end
  endtask

  // Run the current A program to done and compare everything against the model.
  task automatic run_a(input string tag, input bit hold, input int poke);
    int k, bq, breg, bre, bwe, bdbl;
    bit ok;
    model_a();
    bq = a_irl_q.size(); breg = a_nreg; bre = a_nre; bwe = a_nwe; bdbl = a_dbl;
    @(negedge clk);
    a_start = 1'b1;
    k = 0;
    while (k < BUDGET) begin
      @(posedge clk); #1;
      k++;
      if (k == 1 && !hold) a_start = 1'b0;
      if (poke != 0 && k == poke) a_start = 1'b1;
      if (poke != 0 && k == poke + 1) a_start = 1'b0;
      if (a_done) break;
    end
    tests++; if (k !== m_cyc + 1) begin fails++; $display("FAIL %s latency: got %0d expected %0d", tag, k, m_cyc + 1); end
    tests++; if (int'(a_cyc) !== m_cyc) begin fails++; $display("FAIL %s cycle_count: got %0d expected %0d", tag, a_cyc, m_cyc); end
    tests++; if (int'(a_ins) !== m_ins) begin fails++; $display("FAIL %s instr_count: got %0d expected %0d", tag, a_ins, m_ins); end
    tests++; if (int'(a_pc) !== m_pc) begin fails++; $display("FAIL %s pc: got %0d expected %0d", tag, a_pc, m_pc); end
    tests++; if (a_nreg - breg !== m_reg) begin fails++; $display("FAIL %s reg_we: got %0d expected %0d", tag, a_nreg - breg, m_reg); end
    tests++; if (a_nre - bre !== m_re) begin fails++; $display("FAIL %s mem_re: got %0d expected %0d", tag, a_nre - bre, m_re); end
    tests++; if (a_nwe - bwe !== m_we) begin fails++; $display("FAIL %s mem_we: got %0d expected %0d", tag, a_nwe - bwe, m_we); end
    tests++; if (a_dbl - bdbl !== 0) begin fails++; $display("FAIL %s mem_we_width: got %0d wide pulses expected 0", tag, a_dbl - bdbl); end
    ok = ((a_irl_q.size() - bq) == m_pcs.size());
    if (ok) foreach (m_pcs[i]) if (a_irl_q[bq + i] != m_pcs[i]) ok = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL %s fetch_pcs: got %0d fetches expected %0d", tag, a_irl_q.size() - bq, m_pcs.size()); end
  endtask

  // Run the current B program to done and compare against values from the cycle rules.
  task automatic run_b(input string tag, input int e_lat, input int e_cyc, input int e_ins,
                       input int e_pc, input int e_re, input int e_we);
    int k, bre, bwe;
    bre = b_nre; bwe = b_nwe;
    @(negedge clk);
    b_start = 1'b1;
    k = 0;
    while (k < BUDGET) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) b_start = 1'b0;
      if (b_done) break;
    end
    tests++; if (k !== e_lat) begin fails++; $display("FAIL %s latency: got %0d expected %0d", tag, k, e_lat); end
    tests++; if (int'(b_cyc) !== e_cyc) begin fails++; $display("FAIL %s cycle_count: got %0d expected %0d", tag, b_cyc, e_cyc); end
    tests++; if (int'(b_ins) !== e_ins) begin fails++; $display("FAIL %s instr_count: got %0d expected %0d", tag, b_ins, e_ins); end
    tests++; if (int'(b_pc) !== e_pc) begin fails++; $display("FAIL %s pc: got %0d expected %0d", tag, b_pc, e_pc); end
    tests++; if (b_nre - bre !== e_re) begin fails++; $display("FAIL %s mem_re: got %0d expected %0d", tag, b_nre - bre, e_re); end
    tests++; if (b_nwe - bwe !== e_we) begin fails++; $display("FAIL %s mem_we: got %0d expected %0d", tag, b_nwe - bwe, e_we); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests++; if (a_pc !== '0) begin fails++; $display("FAIL reset_pc_a: got %0d expected 0", a_pc); end
    tests++; if ({a_ir_load, a_reg_we, a_mem_re, a_mem_we, a_done} !== 5'b0) begin fails++; $display("FAIL reset_outs_a: got %b expected 00000", {a_ir_load, a_reg_we, a_mem_re, a_mem_we, a_done}); end
    tests++; if (a_cyc !== '0 || a_ins !== '0) begin fails++; $display("FAIL reset_counts_a: got %0d/%0d expected 0/0", a_cyc, a_ins); end
    tests++; if (b_pc !== '0) begin fails++; $display("FAIL reset_pc_b: got %0d expected 0", b_pc); end
    tests++; if ({b_ir_load, b_reg_we, b_mem_re, b_mem_we, b_done} !== 5'b0) begin fails++; $display("FAIL reset_outs_b: got %b expected 00000", {b_ir_load, b_reg_we, b_mem_re, b_mem_we, b_done}); end
    tests++; if (b_cyc !== '0 || b_ins !== '0) begin fails++; $display("FAIL reset_counts_b: got %0d/%0d expected 0/0", b_cyc, b_ins); end
  endtask

  task automatic test_straight_line();
    clear_prog_a();
    pa_op[0] = OP_ADD;   pa_halt[0] = 1'b0;
    pa_op[1] = OP_LOAD;  pa_halt[1] = 1'b0;
    pa_op[2] = OP_STORE; pa_halt[2] = 1'b0;
    run_a("straight", 1'b0, 0);
  endtask

  task automatic test_bne();
    clear_prog_a();
    pa_op[0] = OP_BNE; pa_halt[0] = 1'b0; pa_ne[0] = 1'b1; pa_tgt[0] = 4'h5;
    pa_op[5] = OP_BNE; pa_halt[5] = 1'b0; pa_ne[5] = 1'b0; pa_tgt[5] = 4'h1;
    run_a("bne", 1'b0, 0);
  endtask

  task automatic test_start_ignored();
    clear_prog_a();
    pa_op[0] = OP_ADD;   pa_halt[0] = 1'b0;
    pa_op[1] = OP_LOAD;  pa_halt[1] = 1'b0;
    pa_op[2] = OP_STORE; pa_halt[2] = 1'b0;
    pa_op[3] = OP_NAND;  pa_halt[3] = 1'b0;
    run_a("start_in_exec", 1'b0, 3);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      clear_prog_a();
      for (int i = 0; i < int'(A_DEPTH) - 1; i++) begin
        pa_op[i]   = 3'($urandom_range(7, 0));
        pa_halt[i] = ($urandom_range(9, 0) == 0);
        pa_ne[i]   = 1'($urandom_range(1, 0));
        pa_tgt[i]  = 4'($urandom_range(int'(A_DEPTH) - 1, i + 1));
      end
      run_a($sformatf("random%0d", r), 1'b0, 0);
    end
  endtask

  task automatic test_restart();
    int hold_pc, k;
    clear_prog_a();
    pa_op[0] = OP_MOVE; pa_halt[0] = 1'b0;
    pa_op[1] = OP_SET;  pa_halt[1] = 1'b0;
    run_a("restart_first", 1'b1, 0);
    hold_pc = int'(a_pc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++; if (a_done !== 1'b1 || int'(a_pc) !== hold_pc) begin fails++; $display("FAIL restart_held: got done=%b pc=%0d expected done=1 pc=%0d", a_done, a_pc, hold_pc); end
    end
    @(negedge clk); a_start = 1'b0;
    @(negedge clk); a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    tests++; if ({a_ir_load, a_done} !== 2'b10) begin fails++; $display("FAIL restart_fetch: got ir_load/done=%b expected 10", {a_ir_load, a_done}); end
    tests++; if (a_pc !== '0 || a_cyc !== '0 || a_ins !== '0) begin fails++; $display("FAIL restart_clear: got pc=%0d cyc=%0d ins=%0d expected 0/0/0", a_pc, a_cyc, a_ins); end
    k = 1;
    while (k < BUDGET && !a_done) begin
      @(posedge clk); #1;
      k++;
    end
    tests++; if (int'(a_cyc) !== m_cyc || int'(a_ins) !== m_ins) begin fails++; $display("FAIL restart_rerun: got cyc=%0d ins=%0d expected %0d/%0d", a_cyc, a_ins, m_cyc, m_ins); end
  endtask

  task automatic test_wrap();
    int k;
    clear_prog_a();
    for (int i = 0; i < int'(A_DEPTH); i++) begin
      pa_op[i] = OP_ADD; pa_halt[i] = 1'b0;
    end
    @(negedge clk);
    a_start = 1'b1;
    k = 0;
    while (k < BUDGET) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) a_start = 1'b0;
      if (int'(a_ins) == int'(A_DEPTH)) break;
    end
    tests++; if (a_pc !== '0) begin fails++; $display("FAIL wrap_pc: got %0d expected 0", a_pc); end
    tests++; if (a_ir_load !== 1'b1) begin fails++; $display("FAIL wrap_fetch: got ir_load=%b expected 1", a_ir_load); end
    pa_halt[0] = 1'b1;
    while (k < BUDGET && !a_done) begin
      @(posedge clk); #1;
      k++;
    end
    tests++; if (int'(a_cyc) !== int'(A_DEPTH) * 4 + 2) begin fails++; $display("FAIL wrap_cycles: got %0d expected %0d", a_cyc, A_DEPTH * 4 + 2); end
    tests++; if (int'(a_ins) !== int'(A_DEPTH)) begin fails++; $display("FAIL wrap_instr: got %0d expected %0d", a_ins, A_DEPTH); end
  endtask

  task automatic test_mem_lat3();
    int cyc;
    clear_prog_b();
    pb_op[0] = OP_STORE; pb_halt[0] = 1'b0;
    pb_op[1] = OP_LOAD;  pb_halt[1] = 1'b0;
    cyc = (3 + B_LAT) + (4 + B_LAT) + 2;
    run_b("memlat3", cyc + 1, (cyc > B_SAT) ? B_SAT : cyc, 2, 2, B_LAT, 1);
  endtask

  task automatic test_saturate();
    int cyc;
    clear_prog_b();
    for (int i = 0; i < 20; i++) begin
      pb_op[i] = OP_ROR; pb_halt[i] = 1'b0;
    end
    cyc = 20 * 4 + 2;
    run_b("saturate", cyc + 1, (cyc > B_SAT) ? B_SAT : cyc, (20 > B_SAT) ? B_SAT : 20, 20, 0, 0);
  endtask

  task automatic test_reset_mid_mem();
    int k;
    bit seen;
    clear_prog_b();
    pb_op[0] = OP_ADD;   pb_halt[0] = 1'b0;
    pb_op[1] = OP_ADD;   pb_halt[1] = 1'b0;
    pb_op[2] = OP_STORE; pb_halt[2] = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    k = 0; seen = 1'b0;
    while (k < BUDGET) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) b_start = 1'b0;
      if (b_mem_we) begin seen = 1'b1; break; end
    end
    tests++; if (!seen || k !== 4 + 4 + 3 + 1) begin fails++; $display("FAIL midmem_first_mem: got cycle %0d seen=%0d expected cycle 12", k, seen); end
    @(posedge clk); #1;
    tests++; if (b_mem_we !== 1'b0 || int'(b_pc) !== 2) begin fails++; $display("FAIL midmem_second_mem: got mem_we=%b pc=%0d expected 0/2", b_mem_we, b_pc); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if ({b_ir_load, b_reg_we, b_mem_re, b_mem_we, b_done} !== 5'b0) begin fails++; $display("FAIL midmem_reset_outs: got %b expected 00000", {b_ir_load, b_reg_we, b_mem_re, b_mem_we, b_done}); end
    tests++; if (b_pc !== '0 || b_cyc !== '0 || b_ins !== '0) begin fails++; $display("FAIL midmem_reset_regs: got pc=%0d cyc=%0d ins=%0d expected 0/0/0", b_pc, b_cyc, b_ins); end
    @(posedge clk); #1;
    tests++; if ({b_ir_load, b_reg_we, b_mem_re, b_mem_we, b_done} !== 5'b0) begin fails++; $display("FAIL midmem_idle_outs: got %b expected 00000", {b_ir_load, b_reg_we, b_mem_re, b_mem_we, b_done}); end
  endtask

  initial begin
    clear_prog_a();
    clear_prog_b();
    test_reset();
    test_straight_line();
    test_bne();
    test_start_ignored();
    test_random();
    test_restart();
    test_wrap();
    test_mem_lat3();
    test_saturate();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
